// File: rtl/armleocpu_axi_lrsc_initiator.sv
// rtl/armleocpu_axi_lrsc_initiator.sv - single-outstanding AXI4 host for LOAD/STORE/LR/SC commands
//
// Purpose: accepts one command at a time on a ready/valid request port and
// turns it into a single-beat AXI4 read (LOAD, LR) or write (STORE, SC).
// LR/SC use AXI exclusive access (arlock/awlock). The bus response is
// classified into resp_rdata/resp_err and returned on the response port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      command handshake (req_ready only while idle)
//   req_cmd                  0=LOAD 1=STORE 2=LR 3=SC
//   req_addr/req_size        address and AXI size
//   req_wdata/req_wstrb      store data and byte strobes
//   resp_valid/resp_ready    result handshake
//   resp_rdata               load data; for SC 0=success, 1=failure
//   resp_err                 bus error, ID mismatch or exclusive not granted
//   axi_aw*/axi_w*/axi_b*    AXI4 write host channels
//   axi_ar*/axi_r*           AXI4 read host channels
//
// Option: define ARMLEOCPU_LRSC_LOCAL_RESERVATION_EN to add a local
// reservation register; an SC that misses it fails without touching the bus.

module armleocpu_axi_lrsc_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_STROBES = DATA_WIDTH / 8,
  parameter logic [ID_WIDTH-1:0] AXI_ID = '0
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_cmd,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [2:0]              req_size,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_STROBES-1:0] req_wstrb,

  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,

  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic [2:0]              axi_awsize,
  output logic [1:0]              axi_awburst,
  output logic [ID_WIDTH-1:0]     axi_awid,
  output logic                    axi_awlock,

  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_STROBES-1:0] axi_wstrb,
  output logic                    axi_wlast,

  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  input  logic [1:0]              axi_bresp,
  input  logic [ID_WIDTH-1:0]     axi_bid,

  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic [2:0]              axi_arsize,
  output logic [1:0]              axi_arburst,
  output logic [ID_WIDTH-1:0]     axi_arid,
  output logic                    axi_arlock,

  input  logic                    axi_rvalid,
  output logic                    axi_rready,
  input  logic [1:0]              axi_rresp,
  input  logic                    axi_rlast,
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic [ID_WIDTH-1:0]     axi_rid
);

  localparam logic [1:0] CMD_LOAD  = 2'd0;
  localparam logic [1:0] CMD_STORE = 2'd1;
  localparam logic [1:0] CMD_LR    = 2'd2;
  localparam logic [1:0] CMD_SC    = 2'd3;

  localparam logic [1:0] RESP_EXOKAY = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AR    = 3'd1,
    S_R     = 3'd2,
    S_WRITE = 3'd3,
    S_B     = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t                  state;
  logic                    aw_done;
  logic                    w_done;
  logic [1:0]              cmd_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [2:0]              size_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [DATA_STROBES-1:0] wstrb_r;

  // Payload is driven straight from the latched command so it stays stable
  // for as long as the corresponding valid is held.
  assign axi_awaddr  = addr_r;
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = size_r;
  assign axi_awburst = 2'b01;
  assign axi_awid    = AXI_ID;
  assign axi_awlock  = (cmd_r == CMD_SC);
  assign axi_wdata   = wdata_r;
  assign axi_wstrb   = wstrb_r;
  assign axi_wlast   = 1'b1;
  assign axi_araddr  = addr_r;
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = size_r;
  assign axi_arburst = 2'b01;
  assign axi_arid    = AXI_ID;
  assign axi_arlock  = (cmd_r == CMD_LR);

  // Response classification, shared between the R and B states.
  logic [1:0] bus_resp;
  logic       bus_fault;
  logic       cls_err;
  logic       sc_fail;
  logic       aw_fin;
  logic       w_fin;

  always_comb begin
    bus_resp  = (state == S_R) ? axi_rresp : axi_bresp;
    // A wrong ID, or a read beat not flagged last, means the beat is not ours.
    bus_fault = bus_resp[1] |
                ((state == S_R) ? ((axi_rid != AXI_ID) | ~axi_rlast) : (axi_bid != AXI_ID));
    sc_fail   = bus_fault | (bus_resp != RESP_EXOKAY);
    // Only LR treats a plain OKAY as an error; a failed SC is a normal result.
    cls_err   = (cmd_r == CMD_LR) ? sc_fail : bus_fault;
    aw_fin    = aw_done | (axi_awvalid & axi_awready);
    w_fin     = w_done  | (axi_wvalid  & axi_wready);
  end

  // SC that cannot succeed locally is answered without a bus transaction.
  logic skip_sc;
`ifdef ARMLEOCPU_LRSC_LOCAL_RESERVATION_EN
  logic                  res_valid;
  logic [ADDR_WIDTH-1:0] res_addr;
  logic                  res_hit;

  always_comb begin
    res_hit = res_valid & (res_addr == req_addr);
    skip_sc = (req_cmd == CMD_SC) & ~res_hit;
  end
`else
  always_comb begin
    skip_sc = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      cmd_r       <= CMD_LOAD;
      addr_r      <= '0;
      size_r      <= 3'd0;
      wdata_r     <= '0;
      wstrb_r     <= '0;
`ifdef ARMLEOCPU_LRSC_LOCAL_RESERVATION_EN
      res_valid   <= 1'b0;
      res_addr    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            cmd_r     <= req_cmd;
            addr_r    <= req_addr;
            size_r    <= req_size;
            wdata_r   <= req_wdata;
            wstrb_r   <= req_wstrb;
`ifdef ARMLEOCPU_LRSC_LOCAL_RESERVATION_EN
            if (req_cmd[0] && res_hit)
              res_valid <= 1'b0;
`endif
            if (skip_sc) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= {{(DATA_WIDTH-1){1'b0}}, 1'b1};
              resp_err   <= 1'b0;
            end else if (!req_cmd[0]) begin
              // LOAD and LR are the even encodings.
              state       <= S_AR;
              axi_arvalid <= 1'b1;
            end else begin
              state       <= S_WRITE;
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        S_AR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= S_R;
          end
        end

        S_R: begin
          if (axi_rvalid) begin
            axi_rready <= 1'b0;
            resp_rdata <= axi_rdata;
            resp_err   <= cls_err;
            resp_valid <= 1'b1;
            state      <= S_RESP;
`ifdef ARMLEOCPU_LRSC_LOCAL_RESERVATION_EN
            if (cmd_r == CMD_LR && !cls_err) begin
              res_valid <= 1'b1;
              res_addr  <= addr_r;
            end
`endif
          end
        end

        S_WRITE: begin
          if (axi_awvalid && axi_awready) begin
            axi_awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (axi_wvalid && axi_wready) begin
            axi_wvalid <= 1'b0;
            w_done     <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            axi_bready <= 1'b1;
            state      <= S_B;
          end
        end

        S_B: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            resp_rdata <= {{(DATA_WIDTH-1){1'b0}}, (cmd_r == CMD_SC) & sc_fail};
            resp_err   <= cls_err;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end

        S_RESP: begin
          // req_ready stays low here, giving one idle cycle before the next command.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_axi_lrsc_initiator.sv
// tb/tb_armleocpu_axi_lrsc_initiator.sv - self-checking bench for armleocpu_axi_lrsc_initiator

module tb_armleocpu_axi_lrsc_initiator;

  localparam logic [1:0] LOAD = 2'd0, STORE = 2'd1, LR = 2'd2, SC = 2'd3;
  localparam logic [1:0] OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_cmd;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic [3:0]  axi_awid;
  logic        axi_awlock;
  logic        axi_wvalid, axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;
  logic [3:0]  axi_bid;
  logic        axi_arvalid, axi_arready;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic [3:0]  axi_arid;
  logic        axi_arlock;
  logic        axi_rvalid, axi_rready;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic [31:0] axi_rdata;
  logic [3:0]  axi_rid;

  always #5 clk = ~clk;

  armleocpu_axi_lrsc_initiator dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awid(axi_awid), .axi_awlock(axi_awlock),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arid(axi_arid), .axi_arlock(axi_arlock),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rdata(axi_rdata), .axi_rid(axi_rid)
  );

  int checks = 0;
  int errors = 0;

  // Reference reservation: what the local monitor should hold after each command.
  logic        m_res_v = 1'b0;
  logic [31:0] m_res_a = 32'd0;

  // Observations of the last transaction.
  logic [31:0] t_rdata;
  logic        t_err;
  int          t_ar, t_aw, t_w, t_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic txn(input string tag, input logic [1:0] cmd, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] rsp, input logic bad_id,
                     input logic [31:0] rd, input int ar_d, input int aw_d, input int w_d,
                     input int b_d, input int r_d);
    logic skip, is_rd, bus_err, exp_err, chk_rd, done, r_given, b_given;
    logic p_arv, p_awv, p_wv, p_bready, p_rready, p_respv;
    logic [31:0] exp_rd, cap_rdata;
    logic cap_err;
    int ar_w, aw_w, w_w, b_w, resp_w, wait_c;

    skip = 1'b0;
`ifdef ARMLEOCPU_LRSC_LOCAL_RESERVATION_EN
    skip = (cmd == SC) && !(m_res_v && m_res_a == addr);
    if ((cmd == STORE || cmd == SC) && m_res_v && m_res_a == addr) m_res_v = 1'b0;
`endif
    is_rd = (cmd == LOAD || cmd == LR);

    wait_c = 0;
    while (!req_ready && wait_c < 20) begin @(negedge clk); wait_c++; end
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    if (!req_ready) return;

    req_valid = 1'b1; req_cmd = cmd; req_addr = addr; req_size = 3'd2;
    req_wdata = wdata; req_wstrb = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;

    t_ar = 0; t_aw = 0; t_w = 0; t_b = 0; t_rdata = 'x; t_err = 1'bx;
    done = 0; r_given = 0; b_given = 0;
    p_arv = 0; p_awv = 0; p_wv = 0; p_bready = 0; p_rready = 0; p_respv = 0;
    ar_w = 0; aw_w = 0; w_w = 0; b_w = 0; resp_w = 0;
    cap_rdata = 0; cap_err = 0;

    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      // Handshakes completed on the edge just passed.
      if (p_arv && axi_arready) t_ar++;
      if (p_awv && axi_awready) t_aw++;
      if (p_wv && axi_wready) t_w++;
      if (axi_bvalid && p_bready) begin t_b++; axi_bvalid = 1'b0; end
      if (axi_rvalid && p_rready) axi_rvalid = 1'b0;
      if (p_arv && !axi_arready) check({tag, "_arvalid_hold"}, 32'(axi_arvalid), 32'd1);
      if (p_awv && !axi_awready) check({tag, "_awvalid_hold"}, 32'(axi_awvalid), 32'd1);
      if (p_wv && !axi_wready) check({tag, "_wvalid_hold"}, 32'(axi_wvalid), 32'd1);
      if (p_respv && resp_ready) begin
        done = 1'b1; resp_ready = 1'b0; t_rdata = cap_rdata; t_err = cap_err;
      end else if (p_respv) begin
        check({tag, "_resp_hold"}, 32'(resp_valid), 32'd1);
        check({tag, "_resp_stable"}, resp_rdata, cap_rdata);
      end
      if (!done) begin
        axi_arready = 1'b0;
        if (axi_arvalid) begin
          if (ar_w >= ar_d) begin
            axi_arready = 1'b1;
            check({tag, "_arlock"}, 32'(axi_arlock), 32'(cmd == LR));
            check({tag, "_araddr"}, axi_araddr, addr);
            check({tag, "_arlen_burst"}, {22'd0, axi_arlen, axi_arburst}, {22'd0, 8'd0, 2'b01});
          end else ar_w++;
        end
        axi_awready = 1'b0;
        if (axi_awvalid) begin
          if (aw_w >= aw_d) begin
            axi_awready = 1'b1;
            check({tag, "_awlock"}, 32'(axi_awlock), 32'(cmd == SC));
            check({tag, "_awaddr"}, axi_awaddr, addr);
            check({tag, "_awlen_burst"}, {22'd0, axi_awlen, axi_awburst}, {22'd0, 8'd0, 2'b01});
          end else aw_w++;
        end
        axi_wready = 1'b0;
        if (axi_wvalid) begin
          if (w_w >= w_d) begin
            axi_wready = 1'b1;
            check({tag, "_wdata"}, axi_wdata, wdata);
            check({tag, "_wlast"}, 32'(axi_wlast), 32'd1);
          end else w_w++;
        end
        if (axi_rready && !r_given) begin
          axi_rvalid = 1'b1; axi_rdata = rd; axi_rresp = rsp; axi_rlast = 1'b1;
          axi_rid = bad_id ? 4'd1 : 4'd0; r_given = 1'b1;
        end
        if (axi_bready && !b_given) begin
          if (b_w >= b_d) begin
            axi_bvalid = 1'b1; axi_bresp = rsp; axi_bid = bad_id ? 4'd1 : 4'd0; b_given = 1'b1;
          end else b_w++;
        end
        if (resp_valid) begin
          if (!p_respv) begin cap_rdata = resp_rdata; cap_err = resp_err; end
          if (resp_w >= r_d) resp_ready = 1'b1; else resp_w++;
        end
      end
      p_arv = axi_arvalid; p_awv = axi_awvalid; p_wv = axi_wvalid;
      p_bready = axi_bready; p_rready = axi_rready; p_respv = resp_valid;
      if (!done) @(negedge clk);
    end
    axi_arready = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);

    // Expected outcome from the command/response rules.
    bus_err = rsp[1] || bad_id;
    chk_rd = 1'b1; exp_rd = 32'd0; exp_err = bus_err;
    case (cmd)
      LOAD:  exp_rd = rd;
      STORE: chk_rd = 1'b0;
      LR: begin
        exp_rd = rd;
        exp_err = bus_err || (rsp != EXOKAY);
`ifdef ARMLEOCPU_LRSC_LOCAL_RESERVATION_EN
        if (!exp_err) begin m_res_v = 1'b1; m_res_a = addr; end
`endif
      end
      default: begin
        if (skip) begin exp_err = 1'b0; exp_rd = 32'd1; end
        else begin exp_rd = (rsp == EXOKAY) ? 32'd0 : 32'd1; chk_rd = !bus_err; end
      end
    endcase
    check({tag, "_err"}, 32'(t_err), 32'(exp_err));
    if (chk_rd) check({tag, "_rdata"}, t_rdata, exp_rd);
    check({tag, "_ar_count"}, 32'(t_ar), is_rd ? 32'd1 : 32'd0);
    check({tag, "_aw_count"}, 32'(t_aw), (!is_rd && !skip) ? 32'd1 : 32'd0);
    check({tag, "_w_count"}, 32'(t_w), (!is_rd && !skip) ? 32'd1 : 32'd0);
    check({tag, "_b_count"}, 32'(t_b), (!is_rd && !skip) ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [1:0] cmd, rsp;
    logic [31:0] addr;
    int k;

    rst = 1'b1; req_valid = 0; req_cmd = 0; req_addr = 0; req_size = 0; req_wdata = 0; req_wstrb = 0;
    resp_ready = 0; axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0; axi_bid = 0;
    axi_arready = 0; axi_rvalid = 0; axi_rresp = 0; axi_rlast = 0; axi_rdata = 0; axi_rid = 0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_valids", {26'd0, axi_arvalid, axi_awvalid, axi_wvalid, axi_bready, axi_rready, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    txn("lr_exok", LR, 32'h100, 32'd0, EXOKAY, 1'b0, 32'hCAFE, 1, 0, 0, 0, 0);
    check("lr_exok_cafe", t_rdata, 32'hCAFE);
    txn("sc_exok", SC, 32'h100, 32'h5, EXOKAY, 1'b0, 32'd0, 0, 0, 3, 1, 2);
    check("sc_exok_zero", t_rdata, 32'd0);
    txn("sc_okay", SC, 32'h100, 32'h7, OKAY, 1'b0, 32'd0, 0, 1, 0, 0, 0);
    check("sc_okay_one", t_rdata, 32'd1);
    txn("lr_okay", LR, 32'h100, 32'd0, OKAY, 1'b0, 32'h1234, 0, 0, 0, 0, 1);
    check("lr_okay_err", 32'(t_err), 32'd1);
    txn("st_slverr", STORE, 32'h40, 32'hAA55, SLVERR, 1'b0, 32'd0, 0, 0, 0, 2, 0);
    check("st_slverr_err", 32'(t_err), 32'd1);
    txn("ld_badid", LOAD, 32'h80, 32'd0, OKAY, 1'b1, 32'h77, 0, 0, 0, 0, 0);
    txn("ld_decerr", LOAD, 32'h84, 32'd0, DECERR, 1'b0, 32'h99, 2, 0, 0, 0, 0);

    txn("res_lr", LR, 32'h100, 32'd0, EXOKAY, 1'b0, 32'h11, 0, 0, 0, 0, 0);
    txn("res_st", STORE, 32'h100, 32'h22, OKAY, 1'b0, 32'd0, 0, 0, 0, 0, 0);
    txn("res_sc", SC, 32'h100, 32'h33, EXOKAY, 1'b0, 32'd0, 0, 0, 0, 0, 0);
`ifdef ARMLEOCPU_LRSC_LOCAL_RESERVATION_EN
    check("res_sc_no_aw", 32'(t_aw), 32'd0);
    check("res_sc_fail", t_rdata, 32'd1);
`else
    check("res_sc_aw", 32'(t_aw), 32'd1);
    check("res_sc_ok", t_rdata, 32'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      cmd = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: addr = 32'h40;
        1: addr = 32'h100;
        default: addr = 32'h200;
      endcase
      if (cmd == LOAD || cmd == STORE) begin
        rsp = 2'($urandom_range(0, 2));
        if (rsp == EXOKAY) rsp = DECERR;
      end else rsp = 2'($urandom_range(0, 3));
      txn("rand", cmd, addr, $urandom, rsp, ($urandom_range(0, 7) == 0), $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while waiting for B abandons the store silently.
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    req_valid = 1'b1; req_cmd = STORE; req_addr = 32'h300; req_wdata = 32'h1; req_wstrb = 4'hF;
    axi_awready = 1'b1; axi_wready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!axi_bready && k < 20) begin @(negedge clk); k++; end
    check("rstb_wait", 32'(axi_bready), 32'd1);
    axi_awready = 1'b0; axi_wready = 1'b0;
    rst = 1'b1; m_res_v = 1'b0;
    @(negedge clk);
    check("rstb_valids", {26'd0, axi_arvalid, axi_awvalid, axi_wvalid, axi_bready, axi_rready, resp_valid}, 32'd0);
    check("rstb_req_ready_low", 32'(req_ready), 32'd0);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("rstb_no_resp", 32'(resp_valid), 32'd0);
    end
    check("rstb_req_ready", 32'(req_ready), 32'd1);
    txn("post_rst_ld", LOAD, 32'h10, 32'd0, OKAY, 1'b0, 32'hBEEF, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
